pulse_burst_scheduler: RTL and testbench
========================================

Name: pulse_burst_scheduler

Overview:
Upstream command stage for the clock pulser. Accepts pulse-count requests over a valid/ready handshake and buffers them in a small FIFO. Issues each request to the pulser as start/num_pulses. Tracks pulser activity via its last_pulse output, so bursts either chain gaplessly or are separated by a programmable idle gap.

Parameters:
DEPTH, 4, request FIFO entries (power of 2, >=2)
CNT_W, 4, pulse-count width; matches pulser num_pulses
GAP_CYCLES, 0, idle cycles forced between bursts (0 = gapless chaining)
DRAIN_CYCLES, 2**CNT_W-1, post-reset wait covering the longest possible in-flight burst

Ports:
clk  in  1  system clock, posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_count  in  CNT_W  requested pulse count
req_ready  out  1  request accepted when req_valid & req_ready
flush  in  1  discard all queued requests; current burst unaffected
pulser_start  out  1  to pulser start
pulser_num  out  CNT_W  to pulser num_pulses
pulser_last  in  1  from pulser last_pulse
busy  out  1  pulser burst in flight (scheduler's model)
fifo_level  out  $clog2(DEPTH+1)  queued entries
zero_drop  out  1  registered 1-cycle pulse: a zero-count request was accepted and discarded

Behaviour:
- Reset (async assert, sync-style release): state=DRAIN, drain counter=DRAIN_CYCLES, FIFO empty. Output reset values: fifo_level=0, busy=0, zero_drop=0, pulser_start=0, pulser_num=0.
- Why DRAIN: the pulser has no reset and may be mid-burst, so a start issued then would be silently ignored.
- States:
  - DRAIN: counts down to 0, then goes to IDLE. No starts. Requests are still accepted into the FIFO.
  - IDLE: pulser idle.
  - BUSY: burst in flight.
  - GAP: counts GAP_CYCLES idle cycles, then goes to IDLE.
- req_ready = !full & !flush. There is no bypass, and a pop in the same cycle does not free space for a push.
- Accepted request with req_count==0: not enqueued; zero_drop=1 on the next cycle.
- pulser_num = FIFO head (0 when empty). It is combinational from registered FIFO state.
- pulser_start (combinational) = !empty & !flush & (state==IDLE | (state==BUSY & pulser_last & GAP_CYCLES==0)).
- The pulser_last -> pulser_start path is combinational by design, so gapless chaining lands in the pulser's final active cycle.
- Pop FIFO on every cycle with pulser_start=1.
- Transitions:
  - IDLE & start -> BUSY.
  - BUSY & pulser_last & start -> BUSY (chain).
  - BUSY & pulser_last & no start -> GAP if GAP_CYCLES>0, else IDLE.
  - BUSY & !pulser_last -> BUSY.
- busy = (state==BUSY), registered.
- Burst of N occupies exactly N pulser-active cycles. Start is sampled at edge k; pulser active on cycles k+1..k+N; pulser_last high on cycle k+N.
- pulser_last while not BUSY: ignored.
- Flush:
  - Empties the FIFO next edge (fifo_level=0).
  - Gates pulser_start in the same cycle, so a chain on that cycle is suppressed and BUSY exits normally.
  - A push in the same cycle is refused via req_ready=0.
- Reset mid-burst: immediate return to DRAIN. The queued contents are lost.
- fifo_level is exact after every edge. Push and pop in the same cycle leave it unchanged.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.

Decomposition:
- Package pulse_pkg holds:
  - sched_state_t enum {DRAIN, IDLE, BUSY, GAP}
  - localparam PULSE_CNT_W=4
  - function clog2-based level width helper
- Sub-module pulse_req_fifo: synchronous FIFO (DEPTH, WIDTH) with push, pop, flush, full, empty, level, and head data (show-ahead). Asynchronous active-low reset clears pointers only.
- The scheduler FSM, gap counter and drain counter live in pulse_burst_scheduler.

Test Plan:
- Reset release: with DRAIN_CYCLES=15, push count 3 at cycle 0 -> pulser_start held 0 for 15 cycles. Start asserts on the first IDLE cycle with pulser_num=3. Pulser shows 3 active cycles, and busy falls the cycle after pulser_last.
- Gapless chain (GAP_CYCLES=0): queue 2 then 4 -> second start asserts in the same cycle as the first burst's pulser_last. 6 consecutive pulses with no idle cycle, fifo_level 2->1->0.
- Gap (GAP_CYCLES=2): queue 1,1 -> pulse, exactly 2 idle cycles, then pulse. pulser_start never coincides with pulser_last.
- Full/zero: DEPTH=4, push 5 nonzero counts while the pulser is busy -> req_ready low after 4. Then push count 0 -> accepted, zero_drop pulses once, fifo_level unchanged.
- Flush during chain: queue 5,2,2; flush on the first burst's pulser_last cycle -> no chained start, fifo_level=0 next cycle, state goes to IDLE, only 5 pulses observed.
- Async reset mid-burst: assert rst_n low during a 9-pulse burst -> outputs go to reset values immediately. After release the scheduler waits the full DRAIN window, and the next queued request still yields its exact pulse count.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared types and helpers for the pulse burst scheduler slice.
package pulse_pkg;

  typedef enum logic [1:0] {DRAIN, IDLE, BUSY, GAP} sched_state_t;

  localparam int PULSE_CNT_W = 4;

  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pulse_req_fifo.sv
// Show-ahead synchronous request FIFO; extra pointer bit separates full from empty.
module pulse_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [WIDTH-1:0]             head
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign level   = LW'(wptr - rptr);
  assign head    = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      rptr <= wptr;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage carries no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pulse_burst_scheduler.sv
// Buffers pulse-count requests and issues them to the pulser, chaining gaplessly
// on last_pulse or inserting a programmable idle gap between bursts.
module pulse_burst_scheduler
  import pulse_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int CNT_W        = PULSE_CNT_W,
  parameter int GAP_CYCLES   = 0,
  parameter int DRAIN_CYCLES = 2**CNT_W - 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  input  logic [CNT_W-1:0]              req_count,
  output logic                          req_ready,
  input  logic                          flush,
  output logic                          pulser_start,
  output logic [CNT_W-1:0]              pulser_num,
  input  logic                          pulser_last,
  output logic                          busy,
  output logic [level_w(DEPTH)-1:0]     fifo_level,
  output logic                          zero_drop
);
  localparam int  DW    = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int  GW    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam bit  CHAIN = (GAP_CYCLES == 0);

  sched_state_t   state;
  logic [DW-1:0]  drain_cnt;
  logic [GW-1:0]  gap_cnt;
  logic           full, empty, accept, push, start_ok;

  assign req_ready    = !full && !flush;
  assign accept       = req_valid && req_ready;
  assign push         = accept && (req_count != '0);
  // last_pulse feeds start combinationally so a chained burst lands in the final active cycle.
  assign start_ok     = (state == IDLE) || ((state == BUSY) && pulser_last && CHAIN);
  assign pulser_start = !empty && !flush && start_ok;

  pulse_req_fifo #(.DEPTH(DEPTH), .WIDTH(CNT_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pulser_start),
    .flush (flush),
    .wdata (req_count),
    .full  (full),
    .empty (empty),
    .level (fifo_level),
    .head  (pulser_num)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DRAIN;
      drain_cnt <= DW'(DRAIN_CYCLES);
      gap_cnt   <= '0;
      busy      <= 1'b0;
      zero_drop <= 1'b0;
    end else begin
      zero_drop <= accept && (req_count == '0);
      case (state)
        // The pulser has no reset; wait out any burst that may still be running.
        DRAIN: begin
          if (drain_cnt <= DW'(1)) state <= IDLE;
          if (drain_cnt != '0)     drain_cnt <= drain_cnt - 1'b1;
        end
        IDLE: begin
          if (pulser_start) begin
            state <= BUSY;
            busy  <= 1'b1;
          end
        end
        BUSY: begin
          if (pulser_last && !pulser_start) begin
            busy <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= GW'(GAP_CYCLES);
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt <= GW'(1)) state <= IDLE;
          if (gap_cnt != '0)     gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= DRAIN;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Scoreboarded bench: gapless instance (u0) and 2-cycle-gap instance (u1), each driving a pulser model.
module tb_pulse_burst_scheduler;
  localparam int CW = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid [2];
  logic [CW-1:0] req_count [2];
  logic          req_ready [2];
  logic          flush     [2];
  logic          pstart    [2];
  logic [CW-1:0] pnum      [2];
  logic          plast     [2];
  logic          busy      [2];
  logic [LW-1:0] level     [2];
  logic          zdrop     [2];
  int            rem       [2] = '{0, 0};

  int checks = 0, failures = 0;
  int q0[$], q1[$];
  int extra0 = 0, extra1 = 0;
  int zd_seen0 = 0, zd_seen1 = 0, zd_exp0 = 0;
  int n, k, cnt;

  always #5 clk = ~clk;

  pulse_burst_scheduler #(.DEPTH(4), .CNT_W(CW), .GAP_CYCLES(0), .DRAIN_CYCLES(15)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_count(req_count[0]),
    .req_ready(req_ready[0]), .flush(flush[0]), .pulser_start(pstart[0]), .pulser_num(pnum[0]),
    .pulser_last(plast[0]), .busy(busy[0]), .fifo_level(level[0]), .zero_drop(zdrop[0]));

  pulse_burst_scheduler #(.DEPTH(4), .CNT_W(CW), .GAP_CYCLES(2), .DRAIN_CYCLES(3)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_count(req_count[1]),
    .req_ready(req_ready[1]), .flush(flush[1]), .pulser_start(pstart[1]), .pulser_num(pnum[1]),
    .pulser_last(plast[1]), .busy(busy[1]), .fifo_level(level[1]), .zero_drop(zdrop[1]));

  // Pulser model: no reset, ignores start unless idle or on its last pulse.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pstart[i] && rem[i] <= 1) rem[i] <= int'(pnum[i]);
      else if (rem[i] > 0)          rem[i] <= rem[i] - 1;
    end
  end
  assign plast[0] = (rem[0] == 1);
  assign plast[1] = (rem[1] == 1);

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every issued start must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pstart[0]) begin
        if (q0.size() == 0) extra0++;
        else check("sb0_num", int'(pnum[0]), q0.pop_front());
      end
      if (pstart[1]) begin
        check("gap_start_on_last", int'(plast[1]), 0);
        if (q1.size() == 0) extra1++;
        else check("sb1_num", int'(pnum[1]), q1.pop_front());
      end
      if (zdrop[0]) zd_seen0++;
      if (zdrop[1]) zd_seen1++;
    end
  end

  // Called and returns at posedge+1; one request cycle.
  task automatic push(input int i, input int c, input bit exp_acc, input string nm);
    req_valid[i] = 1'b1;
    req_count[i] = CW'(c);
    @(negedge clk);
    check({nm, "_ready"}, int'(req_ready[i]), int'(exp_acc));
    if (req_ready[i]) begin
      if (c == 0) zd_exp0++;
      else if (i == 0) q0.push_back(c);
      else q1.push_back(c);
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  // Returns at the negedge of the cycle where start is high; w = cycles waited.
  task automatic wait_start(input int i, input string nm, output int w);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!pstart[i] && w < 60);
    if (!pstart[i]) check({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_count[i] = '0;
      flush[i]     = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_level", int'(level[0]), 0);
    check("rst_busy",  int'(busy[0]), 0);
    check("rst_zdrop", int'(zdrop[0]), 0);
    check("rst_start", int'(pstart[0]), 0);
    check("rst_num",   int'(pnum[0]), 0);
    check("rst_level1", int'(level[1]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset release: 15 drain cycles, then burst of 3.
    push(0, 3, 1'b1, "drain_push");
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      if (pstart[0]) break;
      n++;
    end
    check("drain_cycles", n, 15);
    check("drain_level", int'(level[0]), 1);
    k = 0;
    do begin @(negedge clk); k++; end while (!plast[0] && k < 10);
    check("last_busy", int'(busy[0]), 1);
    @(negedge clk);
    check("busy_fall", int'(busy[0]), 0);
    @(posedge clk); #1;

    // Gapless chain 9 -> 2 -> 4.
    push(0, 9, 1'b1, "chain_push9");
    wait_start(0, "chain9", n);
    @(posedge clk); #1;
    push(0, 2, 1'b1, "chain_push2");
    push(0, 4, 1'b1, "chain_push4");
    wait_start(0, "chain2", n);
    check("chain2_on_last", int'(plast[0]), 1);
    check("chain2_level", int'(level[0]), 2);
    wait_start(0, "chain4", n);
    check("chain4_delay", n, 2);
    check("chain4_on_last", int'(plast[0]), 1);
    check("chain4_level", int'(level[0]), 1);
    @(negedge clk);
    check("chain_level0", int'(level[0]), 0);
    @(posedge clk); #1;

    // Full / zero-count handling.
    push(0, 9, 1'b1, "full_push9");
    wait_start(0, "full9", n);
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) push(0, 4, 1'b1, "full_fill");
    push(0, 4, 1'b0, "full_refuse");
    check("full_level", int'(level[0]), 4);
    wait_start(0, "full_chain", n);
    check("full_chain_level", int'(level[0]), 4);
    @(posedge clk); #1;
    push(0, 0, 1'b1, "zero_push");
    @(negedge clk);
    check("zero_level", int'(level[0]), 3);
    check("zero_pulse", int'(zdrop[0]), 1);
    @(negedge clk);
    check("zero_pulse_end", int'(zdrop[0]), 0);

    k = 0;
    do begin @(negedge clk); k++; end while ((busy[0] || level[0] != 0) && k < 100);
    check("idle_before_flush", int'(busy[0]), 0);
    @(posedge clk); #1;

    // Flush on the last pulse of the first burst.
    push(0, 5, 1'b1, "flush_push5");
    wait_start(0, "flush5", n);
    @(posedge clk); #1;
    push(0, 2, 1'b1, "flush_push2a");
    push(0, 2, 1'b1, "flush_push2b");
    k = 0;
    while (!plast[0] && k < 20) begin @(posedge clk); #1; k++; end
    flush[0] = 1'b1;
    req_valid[0] = 1'b1;
    req_count[0] = 4'd7;
    @(negedge clk);
    check("flush_gate_start", int'(pstart[0]), 0);
    check("flush_ready", int'(req_ready[0]), 0);
    check("flush_busy", int'(busy[0]), 1);
    @(posedge clk); #1;
    flush[0] = 1'b0;
    req_valid[0] = 1'b0;
    q0.delete();
    check("flush_level", int'(level[0]), 0);
    @(negedge clk);
    check("flush_idle", int'(busy[0]), 0);
    repeat (6) @(posedge clk);
    #1;

    // Async reset mid-burst.
    push(0, 9, 1'b1, "rst_push9");
    wait_start(0, "rst9", n);
    @(posedge clk); #1;
    push(0, 2, 1'b1, "rst_push2");
    repeat (2) @(posedge clk);
    #3;
    check("pre_reset_busy", int'(busy[0]), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  int'(busy[0]), 0);
    check("mid_rst_level", int'(level[0]), 0);
    check("mid_rst_start", int'(pstart[0]), 0);
    check("mid_rst_num",   int'(pnum[0]), 0);
    check("mid_rst_zdrop", int'(zdrop[0]), 0);
    q0.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(0, 6, 1'b1, "post_rst_push");
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      if (pstart[0]) break;
      n++;
    end
    check("post_rst_drain", n, 15);
    cnt = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (rem[0] > 0) cnt++;
    end while (!plast[0] && k < 30);
    check("post_rst_pulses", cnt, 6);
    @(posedge clk); #1;

    // Gap instance: two 1-pulse bursts separated by 2 GAP cycles.
    push(1, 1, 1'b1, "gap_push_a");
    wait_start(1, "gap_a", n);
    @(posedge clk); #1;
    push(1, 1, 1'b1, "gap_push_b");
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (pstart[1]) break;
      check("gap_busy_low", int'(busy[1]), 0);
      n++;
    end
    check("gap_cycles", n, 2);
    @(posedge clk); #1;

    k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 100) begin @(posedge clk); k++; end
    repeat (4) @(posedge clk);
    check("sb0_drained", q0.size(), 0);
    check("sb1_drained", q1.size(), 0);
    check("sb0_extra_starts", extra0, 0);
    check("sb1_extra_starts", extra1, 0);
    check("zero_drop_count", zd_seen0, zd_exp0);
    check("zero_drop_count1", zd_seen1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
